prod_bin2bcd_seq: RTL and testbench

//  Sequential shift-add-3 (double-dabble) binary-to-BCD converter; downstream of the 6x6 shift-add multiplier.

---
 rtl/prod_bin2bcd_seq.sv | 146 ++++++++++++++
 tb/tb_prod_bin2bcd_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prod_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional BCD_SEG7_EN adds a registered active-low 7-segment decode of each digit.
`timescale 1ns/1ps
module prod_bin2bcd_seq #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
`ifdef BCD_SEG7_EN
  output logic [7*DIGITS-1:0]   seg,
`endif
  output logic [1:0]            state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  // Handshake: start is sampled only in IDLE; busy is high from the accepting
  // edge until the result edge; done is a one-cycle pulse after bcd/ovf update.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    scratch;
  logic [CW-1:0]    cnt;
  logic             sticky;

  logic             load, shift_en, finish;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    scratch_nxt;
  logic [WIDTH-1:0] sr_nxt;
  logic             shift_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_next = S_DONE;
      end
      S_DONE: begin
        finish     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // All digits are corrected in parallel with 4-bit wraparound; no inter-digit carry.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    {shift_out, scratch_nxt, sr_nxt} = {adj, sr, 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      scratch <= '0;
      cnt     <= '0;
      sticky  <= 1'b0;
    end else if (load) begin
      sr      <= bin;
      scratch <= '0;
      cnt     <= '0;
      sticky  <= 1'b0;
    end else if (shift_en) begin
      sr      <= sr_nxt;
      scratch <= scratch_nxt;
      cnt     <= cnt + CW'(1);
      sticky  <= sticky | shift_out;
    end
  end

  // Result registers move only on the completion edge, never exposing scratch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd  <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        bcd <= scratch;
        ovf <= sticky;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

`ifdef BCD_SEG7_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7f;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= '1;
    end else if (finish) begin
      for (int i = 0; i < DIGITS; i++) seg[7*i +: 7] <= seg7(scratch[4*i +: 4]);
    end
  end
`endif

endmodule

// File: tb/tb_prod_bin2bcd_seq.sv
// Directed bench for prod_bin2bcd_seq: 4-digit instance plus a 3-digit instance for overflow.
`timescale 1ns/1ps
module tb_prod_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start3;
  logic [11:0] bin, bin3;
  logic        busy, done, ovf, busy3, done3, ovf3;
  logic [15:0] bcd;
  logic [11:0] bcd3;
  logic [1:0]  state_dbg, state_dbg3;
`ifdef BCD_SEG7_EN
  logic [27:0] seg;
  logic [20:0] seg3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prod_bin2bcd_seq #(.WIDTH(12), .DIGITS(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf),
`ifdef BCD_SEG7_EN
    .seg(seg),
`endif
    .state_dbg(state_dbg)
  );

  prod_bin2bcd_seq #(.WIDTH(12), .DIGITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .bin(bin3),
    .busy(busy3), .done(done3), .bcd(bcd3), .ovf(ovf3),
`ifdef BCD_SEG7_EN
    .seg(seg3),
`endif
    .state_dbg(state_dbg3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns negedges counted from the accepting edge's negedge (1) to the done cycle.
  task automatic run_conv(input logic [11:0] v, output int lat);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check("busy_on_accept", {31'd0, busy}, 32'd1);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_conv3(input logic [11:0] v, output int lat);
    @(negedge clk);
    start3 = 1'b1;
    bin3   = v;
    @(negedge clk);
    start3 = 1'b0;
    lat    = 1;
    while (!done3 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, pulses, cyc, n;
    int t[2];
    logic [15:0] v[2];
    logic [15:0] seen;

    rst = 1'b0; start = 1'b0; bin = '0; start3 = 1'b0; bin3 = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd", {16'd0, bcd}, 32'h0000);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);
`ifdef BCD_SEG7_EN
    check("reset_seg", {4'd0, seg}, 32'h0fff_ffff);
`endif
    rst = 1'b1;

    // Zero input and latency
    run_conv(12'd0, lat);
    check("zero_latency", lat - 1, 32'd13);
    check("zero_bcd", {16'd0, bcd}, 32'h0000);
    check("zero_ovf", {31'd0, ovf}, 32'd0);
    check("done_excl_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    run_conv(12'd3969, lat);
    check("bcd_3969", {16'd0, bcd}, 32'h3969);
    check("ovf_3969", {31'd0, ovf}, 32'd0);
    run_conv(12'd4095, lat);
    check("bcd_4095", {16'd0, bcd}, 32'h4095);
    check("lat_4095", lat - 1, 32'd13);

    // Start while busy is ignored; bin changes have no effect
    @(negedge clk);
    start = 1'b1; bin = 12'd100;
    @(negedge clk);
    start = 1'b0; bin = 12'd5;
    repeat (3) @(negedge clk);
    start = 1'b1; bin = 12'd7;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; seen = '0;
    repeat (30) begin
      @(negedge clk);
      if (done) begin pulses++; seen = bcd; end
    end
    check("busy_start_pulses", pulses, 32'd1);
    check("busy_start_bcd", {16'd0, seen}, 32'h0100);
    check("bcd_holds", {16'd0, bcd}, 32'h0100);

    // Reset mid-conversion
    @(negedge clk);
    start = 1'b1; bin = 12'd3969;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_bcd", {16'd0, bcd}, 32'h0000);
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
    check("midrst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", pulses, 32'd0);
    check("midrst_bcd_after", {16'd0, bcd}, 32'h0000);

    // Start held high: back-to-back conversions
    @(negedge clk);
    start = 1'b1; bin = 12'd1;
    @(negedge clk);
    bin = 12'd2;
    cyc = 0; n = 0; t[0] = 0; t[1] = 0; v[0] = '0; v[1] = '0;
    while (n < 2 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (n == 1 && cyc == t[0] + 1) start = 1'b0;
      if (done) begin t[n] = cyc; v[n] = bcd; n++; end
    end
    start = 1'b0;
    check("b2b_pulses", n, 32'd2);
    check("b2b_spacing", t[1] - t[0], 32'd14);
    check("b2b_first", {16'd0, v[0]}, 32'h0001);
    check("b2b_second", {16'd0, v[1]}, 32'h0002);

    // Three-digit instance: overflow and the largest fitting value
    run_conv3(12'd1234, lat);
    check("d3_bcd_1234", {20'd0, bcd3}, 32'h234);
    check("d3_ovf_1234", {31'd0, ovf3}, 32'd1);
    run_conv3(12'd999, lat);
    check("d3_bcd_999", {20'd0, bcd3}, 32'h999);
    check("d3_ovf_999", {31'd0, ovf3}, 32'd0);

    run_conv(12'd8, lat);
    check("bcd_8", {16'd0, bcd}, 32'h0008);
`ifdef BCD_SEG7_EN
    check("seg_8", {4'd0, seg}, {4'd0, 7'h40, 7'h40, 7'h40, 7'h00});
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
